// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample majority vote,
// one-entry holding register with ack handshake, framing and overrun error pulses.
module uart_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]        s_q, s_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              v7_q, v7_d;
    logic              v8_q, v8_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_err_q, overrun_err_d;

    logic tick;
    logic rx_fall;
    logic maj;

    always_comb begin
        rx_meta_d     = rx_pin;
        rx_s_d        = rx_meta_q;
        rx_prev_d     = rx_s_q;
        tick          = (tcnt_q == TCNT_MAX);
        rx_fall       = rx_prev_q & ~rx_s_q;
        // The third vote is the live sample taken at s=9.
        maj           = (v7_q & v8_q) | (v7_q & rx_s_q) | (v8_q & rx_s_q);

        state_d       = state_q;
        tcnt_d        = tick ? '0 : tcnt_q + TCNT_W'(1);
        s_d           = s_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        v7_d          = v7_q;
        v8_d          = v8_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (tick && (s_q == 4'd7)) begin
            v7_d = rx_s_q;
        end
        if (tick && (s_q == 4'd8)) begin
            v8_d = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                // Holding the counters at zero aligns the bit phase to the start edge.
                tcnt_d = '0;
                s_d    = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if ((s_q == 4'd9) && maj) begin
                        state_d = IDLE;
                    end else if (s_q == 4'd15) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd9) begin
                        shreg_d = {maj, shreg_q[7:1]};
                    end
                    if (s_q == 4'd15) begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd9) begin
                        if (maj) begin
                            // A same-cycle ack frees the register, so the new byte wins.
                            if (!rx_valid_q || rx_ack) begin
                                rx_byte_d  = shreg_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_err_d = 1'b1;
                            end
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            s_d         = '0;
                            state_d     = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        s_d = '0;
                    end else if (s_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            tcnt_q        <= '0;
            s_q           <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            v7_q          <= 1'b0;
            v8_q          <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            tcnt_q        <= tcnt_d;
            s_q           <= s_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            v7_q          <= v7_d;
            v8_q          <= v8_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: fast instance (16 clk per bit) plus a default-parameter instance.
module tb_uart_rx;

    localparam int BIT     = 16;
    localparam int BIT_DEF = 16 * 54;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic       rx_ack;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    logic       d_rx_pin;
    logic       d_rx_ack;
    logic [7:0] d_rx_byte;
    logic       d_rx_valid;
    logic       d_rx_busy;
    logic       d_frame_err;
    logic       d_overrun_err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat_sim = 157;

    // Holding-register model
    logic       exp_valid;
    logic [7:0] exp_byte;

    int   fe_cnt = 0, ov_cnt = 0, vr_cnt = 0, br_cnt = 0;
    int   dfe_cnt = 0, dov_cnt = 0;
    logic vprev = 1'b0, bprev = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .rx_busy(rx_busy), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    uart_rx dut_def (
        .clk(clk), .rst(rst), .rx_pin(d_rx_pin), .rx_byte(d_rx_byte), .rx_valid(d_rx_valid),
        .rx_ack(d_rx_ack), .rx_busy(d_rx_busy), .frame_err(d_frame_err), .overrun_err(d_overrun_err)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun_err === 1'b1) ov_cnt++;
        if (d_frame_err === 1'b1) dfe_cnt++;
        if (d_overrun_err === 1'b1) dov_cnt++;
        if (rx_valid === 1'b1 && !vprev) vr_cnt++;
        if (rx_busy === 1'b1 && !bprev) br_cnt++;
        vprev = (rx_valid === 1'b1);
        bprev = (rx_busy === 1'b1);
    end

    task automatic drive_bits(input logic b, input int n);
        rx_pin = b;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_def(input logic b, input int n);
        d_rx_pin = b;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // glitch_bit < 0: clean frame; otherwise a 1-clk inversion near the middle vote of that bit
    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit);
        drive_bits(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive_bits(data[i], 10);
                drive_bits(~data[i], 1);
                drive_bits(data[i], 5);
            end else begin
                drive_bits(data[i], BIT);
            end
        end
        drive_bits(stop, BIT);
    endtask

    task automatic send_and_time(input logic [7:0] data, output int lat);
        int l;
        l = -1;
        fork
            send_frame(data, 1'b1, -1);
            begin
                for (int c = 1; c <= 200 && l < 0; c++) begin
                    @(posedge clk); #1;
                    if (rx_valid === 1'b1) l = c;
                end
            end
        join
        lat = l;
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop_ok, input logic ack_now,
                               output int efe, output int eov);
        efe = 0;
        eov = 0;
        if (!stop_ok) efe = 1;
        else if (!exp_valid || ack_now) begin exp_byte = data; exp_valid = 1'b1; end
        else eov = 1;
    endtask

    task automatic pulse_ack;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; rx_pin = 1'b1; rx_ack = 1'b0; d_rx_pin = 1'b1; d_rx_ack = 1'b0;
        exp_valid = 1'b0; exp_byte = 8'h00;
        repeat (3) begin @(posedge clk); #1; end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_tests++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", rx_byte); end
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        n_tests++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun_err); end
        n_tests++; if (d_rx_valid !== 1'b0 || d_rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_default_dut: got valid=%b byte=%h expected 0 00", d_rx_valid, d_rx_byte); end
        rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
    endtask

    task automatic test_single;
        logic [7:0] b;
        int lat, fe0, ov0, ef, eo;
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            fe0 = fe_cnt; ov0 = ov_cnt;
            model_frame(b, 1'b1, 1'b0, ef, eo);
            send_and_time(b, lat);
            if (k == 0) begin
                n_tests++;
                if (lat < 155 || lat > 157) begin n_fail++; $display("FAIL single_latency: got %0d clks expected 155..157", lat); end
                if (lat > 1) lat_sim = lat;
            end
            n_tests++; if (rx_valid !== exp_valid) begin n_fail++; $display("FAIL single_valid: got %b expected %b", rx_valid, exp_valid); end
            n_tests++; if (rx_byte !== exp_byte) begin n_fail++; $display("FAIL single_byte: got %h expected %h", rx_byte, exp_byte); end
            n_tests++; if (fe_cnt - fe0 != ef || ov_cnt - ov0 != eo) begin n_fail++; $display("FAIL single_flags: got fe=%0d ov=%0d expected %0d %0d", fe_cnt - fe0, ov_cnt - ov0, ef, eo); end
            repeat (20) begin @(posedge clk); #1; end
            n_tests++; if (rx_valid !== 1'b1 || rx_byte !== exp_byte) begin n_fail++; $display("FAIL single_hold: got valid=%b byte=%h expected 1 %h", rx_valid, rx_byte, exp_byte); end
            pulse_ack();
            n_tests++; if (rx_valid !== exp_valid) begin n_fail++; $display("FAIL single_ack_clear: got %b expected %b", rx_valid, exp_valid); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sent[4];
        logic [7:0] got[$];
        int total, run, maxrun;
        bit seen;
        sent[0] = 8'hA3; sent[1] = 8'h0F;
        sent[2] = 8'($urandom_range(0, 255)); sent[3] = 8'($urandom_range(0, 255));
        total = 4 * 10 * BIT + 12;
        run = 0; maxrun = 0; seen = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_frame(sent[i], 1'b1, -1);
                drive_bits(1'b1, 12);
            end
            begin
                for (int c = 0; c < total; c++) begin
                    @(posedge clk); #1;
                    if (rx_valid === 1'b1 && !rx_ack) begin got.push_back(rx_byte); rx_ack = 1'b1; end
                    else rx_ack = 1'b0;
                end
            end
            begin
                for (int c = 0; c < total; c++) begin
                    @(posedge clk); #1;
                    if (rx_busy === 1'b1) begin
                        if (seen && run > maxrun) maxrun = run;
                        run = 0; seen = 1;
                    end else if (seen) run++;
                end
            end
        join
        rx_ack = 1'b0;
        n_tests++; if (got.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= got.size()) begin n_fail++; $display("FAIL b2b_byte%0d: got none expected %h", i, sent[i]); end
            else if (got[i] !== sent[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], sent[i]); end
        end
        n_tests++; if (!seen || maxrun > 7) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d clks (seen=%0d) expected <=7", maxrun, seen); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_overrun;
        logic [7:0] a, b;
        int fe0, ov0, ef1, eo1, ef2, eo2;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 8'h12 : 8'($urandom_range(0, 255));
            b = (k == 0) ? 8'h34 : 8'($urandom_range(0, 255));
            fe0 = fe_cnt; ov0 = ov_cnt;
            model_frame(a, 1'b1, 1'b0, ef1, eo1);
            model_frame(b, 1'b1, 1'b0, ef2, eo2);
            send_frame(a, 1'b1, -1);
            send_frame(b, 1'b1, -1);
            n_tests++; if (ov_cnt - ov0 != eo1 + eo2) begin n_fail++; $display("FAIL overrun_pulse: got %0d cycles expected %0d", ov_cnt - ov0, eo1 + eo2); end
            n_tests++; if (fe_cnt - fe0 != ef1 + ef2) begin n_fail++; $display("FAIL overrun_no_fe: got %0d expected %0d", fe_cnt - fe0, ef1 + ef2); end
            n_tests++; if (rx_byte !== exp_byte || rx_valid !== exp_valid) begin n_fail++; $display("FAIL overrun_keep: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
            pulse_ack();
            n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_clear: got %b expected 0", rx_valid); end
        end
    endtask

    task automatic test_simul_ack;
        logic [7:0] a, b;
        int ov0, ef, eo;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255)) ^ 8'h80;
        model_frame(a, 1'b1, 1'b0, ef, eo);
        send_frame(a, 1'b1, -1);
        ov0 = ov_cnt;
        model_frame(b, 1'b1, 1'b1, ef, eo);
        fork
            send_frame(b, 1'b1, -1);
            begin
                repeat (lat_sim - 1) begin @(posedge clk); #1; end
                rx_ack = 1'b1;
                @(posedge clk); #1;
                rx_ack = 1'b0;
            end
        join
        n_tests++; if (rx_byte !== exp_byte || rx_valid !== exp_valid) begin n_fail++; $display("FAIL simul_ack_load: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
        n_tests++; if (ov_cnt - ov0 != eo) begin n_fail++; $display("FAIL simul_ack_no_overrun: got %0d expected %0d", ov_cnt - ov0, eo); end
        pulse_ack();
    endtask

    task automatic test_frame_err;
        logic [7:0] bad, good;
        int fe0, vr0, ef, eo;
        for (int k = 0; k < 2; k++) begin
            bad  = (k == 0) ? 8'hC5 : 8'($urandom_range(0, 255));
            good = (k == 0) ? 8'h7E : 8'($urandom_range(0, 255));
            fe0 = fe_cnt; vr0 = vr_cnt;
            model_frame(bad, 1'b0, 1'b0, ef, eo);
            send_frame(bad, 1'b0, -1);
            drive_bits(1'b1, BIT);
            n_tests++; if (fe_cnt - fe0 != ef) begin n_fail++; $display("FAIL frame_err_pulse: got %0d cycles expected %0d", fe_cnt - fe0, ef); end
            n_tests++; if (vr_cnt != vr0 || rx_valid !== exp_valid) begin n_fail++; $display("FAIL frame_err_no_valid: got rises=%0d valid=%b expected 0 %b", vr_cnt - vr0, rx_valid, exp_valid); end
            model_frame(good, 1'b1, 1'b0, ef, eo);
            send_frame(good, 1'b1, -1);
            n_tests++; if (rx_valid !== exp_valid || rx_byte !== exp_byte) begin n_fail++; $display("FAIL frame_err_recover: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
            pulse_ack();
        end
        fe0 = fe_cnt;
        drive_bits(1'b0, 30 * BIT);
        drive_bits(1'b1, BIT);
        n_tests++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL break_frame_err: got %0d cycles expected 1", fe_cnt - fe0); end
        good = 8'($urandom_range(0, 255));
        model_frame(good, 1'b1, 1'b0, ef, eo);
        send_frame(good, 1'b1, -1);
        n_tests++; if (rx_valid !== exp_valid || rx_byte !== exp_byte) begin n_fail++; $display("FAIL break_recover: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
        pulse_ack();
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        int fe0, ov0, vr0, br0, gb, ef, eo;
        fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt; br0 = br_cnt;
        drive_bits(1'b0, 5);
        drive_bits(1'b1, 40);
        n_tests++; if (br_cnt - br0 != 1 || rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_false_start: got starts=%0d busy=%b expected 1 0", br_cnt - br0, rx_busy); end
        n_tests++; if (vr_cnt != vr0 || fe_cnt != fe0 || ov_cnt != ov0) begin n_fail++; $display("FAIL glitch_no_output: got valid=%0d fe=%0d ov=%0d expected 0 0 0", vr_cnt - vr0, fe_cnt - fe0, ov_cnt - ov0); end
        for (int k = 0; k < 3; k++) begin
            b  = 8'($urandom_range(0, 255));
            gb = int'($urandom_range(0, 7));
            model_frame(b, 1'b1, 1'b0, ef, eo);
            send_frame(b, 1'b1, gb);
            n_tests++; if (rx_valid !== exp_valid || rx_byte !== exp_byte) begin n_fail++; $display("FAIL glitch_data_bit%0d: got byte=%h valid=%b expected %h %b", gb, rx_byte, rx_valid, exp_byte, exp_valid); end
            pulse_ack();
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] r;
        int ef, eo;
        r = 8'($urandom_range(1, 255));
        model_frame(r, 1'b1, 1'b0, ef, eo);
        send_frame(r, 1'b1, -1);
        drive_bits(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bits(1'b1, BIT);
        rx_pin = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b0; exp_byte = 8'h00;
        n_tests++; if (rx_valid !== exp_valid || rx_byte !== exp_byte) begin n_fail++; $display("FAIL midreset_data: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
        n_tests++; if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b fe=%b ov=%b expected 0 0 0", rx_busy, frame_err, overrun_err); end
        rst = 1'b1;
        drive_bits(1'b1, 20);
        model_frame(8'h81, 1'b1, 1'b0, ef, eo);
        send_frame(8'h81, 1'b1, -1);
        n_tests++; if (rx_valid !== exp_valid || rx_byte !== exp_byte) begin n_fail++; $display("FAIL midreset_recover: got byte=%h valid=%b expected %h %b", rx_byte, rx_valid, exp_byte, exp_valid); end
        pulse_ack();
    endtask

    task automatic test_default;
        logic [7:0] b;
        int lat, fe0, ov0;
        b = 8'h55; lat = -1; fe0 = dfe_cnt; ov0 = dov_cnt;
        fork
            begin
                drive_def(1'b0, BIT_DEF);
                for (int i = 0; i < 8; i++) drive_def(b[i], BIT_DEF);
                drive_def(1'b1, BIT_DEF);
            end
            begin
                for (int c = 1; c <= 9000 && lat < 0; c++) begin
                    @(posedge clk); #1;
                    if (d_rx_valid === 1'b1) lat = c;
                end
            end
        join
        n_tests++; if (lat < 8317 || lat > 8319) begin n_fail++; $display("FAIL default_latency: got %0d clks expected 8317..8319", lat); end
        n_tests++; if (d_rx_valid !== 1'b1 || d_rx_byte !== b) begin n_fail++; $display("FAIL default_byte: got byte=%h valid=%b expected %h 1", d_rx_byte, d_rx_valid, b); end
        n_tests++; if (dfe_cnt != fe0 || dov_cnt != ov0 || d_rx_busy !== 1'b0) begin n_fail++; $display("FAIL default_flags: got fe=%0d ov=%0d busy=%b expected 0 0 0", dfe_cnt - fe0, dov_cnt - ov0, d_rx_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_simul_ack();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_default();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
